// File: rtl/cpld_disp_arbiter.sv
// Round-robin owner of the CPLD LED/7-seg path, switched only on frame strobes, plus sw debounce.
// Optional CPLD_ARB_IDLE_BLANK_EN: blank led/dig0/dig1 on frames with no owner (else hold last).
module cpld_disp_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_FRAMES = 4,
    parameter int unsigned DEB_FRAMES  = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                frame_stb,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    input  logic [8*NREQ-1:0]   led_in,
    input  logic [4*NREQ-1:0]   dig0_in,
    input  logic [4*NREQ-1:0]   dig1_in,
    output logic [7:0]          led,
    output logic [3:0]          dig0,
    output logic [3:0]          dig1,
    input  logic [7:0]          sw_raw,
    output logic [7:0]          sw_db,
    output logic [7:0]          sw_rise
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned DW = $clog2(DEB_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_FRAMES);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [0:0] {StIdle, StOwned} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      led_q, led_d;
    logic [3:0]      dig0_q, dig0_d;
    logic [3:0]      dig1_q, dig1_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [7:0]      deb_prev_q, deb_prev_d;
    logic [7:0]      sw_db_q, sw_db_d;
    logic [7:0]      sw_rise_q, sw_rise_d;

    logic            rr_found;
    logic [IW-1:0]   rr_win;
    logic            grant;
    logic            others;
    logic [7:0]      led_sel;
    logic [3:0]      dig0_sel;
    logic [3:0]      dig1_sel;
    logic            deb_same;
    logic            deb_accept;

    // Round-robin scan starting just after the last granted requester. While owned,
    // last_q equals the owner, so the owner is only found if nobody else requests.
    always_comb begin
        int unsigned   idx_i;
        logic [IW-1:0] idx;
        rr_found = 1'b0;
        rr_win   = '0;
        idx_i    = 0;
        idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_i = (int'(last_q) + k) % NREQ;
            idx   = IW'(idx_i);
            if (!rr_found && req[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx;
            end
        end
    end

    assign others = |(req & ~gnt_q);

    // Owner FSM; everything moves only on frame_stb.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        hold_d  = hold_q;
        grant   = 1'b0;
        if (frame_stb) begin
            case (state_q)
                StIdle: begin
                    if (rr_found) grant = 1'b1;
                end
                StOwned: begin
                    if (!req[own_q]) begin
                        if (rr_found) grant = 1'b1;
                        else          state_d = StIdle;
                    end else if (hold_q >= HOLD_MAX && others) begin
                        grant = 1'b1;
                    end else if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
            if (grant) begin
                state_d = StOwned;
                own_d   = rr_win;
                last_d  = rr_win;
                hold_d  = '0;
            end
        end
    end

    // Data slice of the post-decision owner.
    always_comb begin
        led_sel  = '0;
        dig0_sel = '0;
        dig1_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (own_d == IW'(i)) begin
                led_sel  = led_in[8*i +: 8];
                dig0_sel = dig0_in[4*i +: 4];
                dig1_sel = dig1_in[4*i +: 4];
            end
        end
    end

    always_comb begin
        gnt_d  = gnt_q;
        led_d  = led_q;
        dig0_d = dig0_q;
        dig1_d = dig1_q;
        if (frame_stb) begin
            gnt_d = '0;
            if (state_d == StOwned) begin
                gnt_d[own_d] = 1'b1;
                led_d        = led_sel;
                dig0_d       = dig0_sel;
                dig1_d       = dig1_sel;
            end else begin
`ifdef CPLD_ARB_IDLE_BLANK_EN
                led_d  = '0;
                dig0_d = '0;
                dig1_d = '0;
`else
                led_d  = led_q;
                dig0_d = dig0_q;
                dig1_d = dig1_q;
`endif
            end
        end
    end

    // Debounce: accept sw_raw once it has matched for DEB_FRAMES consecutive frames.
    assign deb_same   = (sw_raw == deb_prev_q);
    assign deb_accept = (DEB_FRAMES == 1) ||
                        (deb_same && (int'(deb_cnt_q) + 1 >= int'(DEB_FRAMES) - 1));

    always_comb begin
        deb_cnt_d  = deb_cnt_q;
        deb_prev_d = deb_prev_q;
        sw_db_d    = sw_db_q;
        sw_rise_d  = '0;
        if (frame_stb) begin
            deb_prev_d = sw_raw;
            if (deb_same) begin
                if (deb_cnt_q < DEB_MAX) deb_cnt_d = deb_cnt_q + DW'(1);
            end else begin
                deb_cnt_d = '0;
            end
            if (deb_accept) begin
                sw_db_d   = sw_raw;
                sw_rise_d = sw_raw & ~sw_db_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            own_q      <= '0;
            last_q     <= LAST_RST;
            hold_q     <= '0;
            gnt_q      <= '0;
            led_q      <= '0;
            dig0_q     <= '0;
            dig1_q     <= '0;
            deb_cnt_q  <= '0;
            deb_prev_q <= '0;
            sw_db_q    <= '0;
            sw_rise_q  <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            gnt_q      <= gnt_d;
            led_q      <= led_d;
            dig0_q     <= dig0_d;
            dig1_q     <= dig1_d;
            deb_cnt_q  <= deb_cnt_d;
            deb_prev_q <= deb_prev_d;
            sw_db_q    <= sw_db_d;
            sw_rise_q  <= sw_rise_d;
        end
    end

    assign gnt     = gnt_q;
    assign led     = led_q;
    assign dig0    = dig0_q;
    assign dig1    = dig1_q;
    assign sw_db   = sw_db_q;
    assign sw_rise = sw_rise_q;

endmodule
